// File: rtl/instr_word_encoder_pkg.sv
// Shared op enum, opcode/funct tables and the word encode function.
// Define INSTR_WORD_ENCODER_FIELD_CHECK_EN to reject malformed field combinations.
package instr_word_encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_SLL,
    OP_SRL,
    OP_ADDI,
    OP_ANDI,
    OP_ORI,
    OP_SLTI,
    OP_LW,
    OP_SW,
    OP_BEQ,
    OP_J    = 4'd14
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef struct packed {
    logic        valid;
    logic        legal;
    logic [31:0] word;
  } stage_t;

  // Returns {legal, word}; word is don't-care when legal is 0.
  function automatic logic [32:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic        legal;
    logic        rtype;
    logic        shift;
    logic [5:0]  funct;
    logic [31:0] word;
    legal = 1'b1;
    rtype = 1'b0;
    shift = 1'b0;
    funct = '0;
    word  = '0;
    unique case (op)
      OP_ADD:  begin rtype = 1'b1; funct = FN_ADD; end
      OP_SUB:  begin rtype = 1'b1; funct = FN_SUB; end
      OP_AND:  begin rtype = 1'b1; funct = FN_AND; end
      OP_OR:   begin rtype = 1'b1; funct = FN_OR;  end
      OP_SLT:  begin rtype = 1'b1; funct = FN_SLT; end
      OP_SLL:  begin
        rtype = 1'b1;
        shift = 1'b1;
        funct = FN_SLL;
      end
      OP_SRL:  begin
        rtype = 1'b1;
        shift = 1'b1;
        funct = FN_SRL;
      end
      OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
      OP_ANDI: word = {OPC_ANDI, rs, rt, imm};
      OP_ORI:  word = {OPC_ORI, rs, rt, imm};
      OP_SLTI: word = {OPC_SLTI, rs, rt, imm};
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      OP_J:    word = {OPC_J, target};
      default: legal = 1'b0;
    endcase
    if (rtype) begin
      word = {OPC_RTYPE, shift ? 5'd0 : rs,
              rt, rd, shamt, funct};
    end
`ifdef INSTR_WORD_ENCODER_FIELD_CHECK_EN
    if (rtype && shift && rs != '0) legal = 1'b0;
    if (rtype && !shift && shamt != '0) legal = 1'b0;
    if (rtype && rd == '0) legal = 1'b0;
    if ((op inside {OP_ADDI, OP_ANDI, OP_ORI,
                    OP_SLTI, OP_LW}) && rt == '0)
      legal = 1'b0;
`endif
    return {legal, word};
  endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Synchronous FIFO with full/empty and same-cycle push/pop when full.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full      = count == FULL_N;
  assign empty     = count == '0;
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Storage needs no reset: the top masks head_data while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_word_encoder.sv
// Field-level request -> 32-bit MIPS word encoder, one stage + output FIFO.
// Define INSTR_WORD_ENCODER_FIELD_CHECK_EN to drop malformed field combinations.
module instr_word_encoder
  import instr_word_encoder_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [31:0]       word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              illegal_op,
  output logic [15:0]       word_count
);

  localparam int EW = ADDR_W + 32;

  stage_t            stage_q;
  logic [32:0]       enc;
  logic [EW-1:0]     head_data;
  logic [ADDR_W-1:0] next_addr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              stage_adv;
  logic              accept;

  assign enc = encode(req_op, req_rs, req_rt, req_rd,
                      req_shamt, req_imm, req_target);

  assign pop       = !fifo_empty && word_ready;
  assign push      = stage_q.valid && stage_q.legal &&
                     (!fifo_full || pop);
  // An illegal stage entry never needs FIFO space.
  assign stage_adv = stage_q.valid &&
                     (!stage_q.legal || !fifo_full || pop);
  assign req_ready = reset_n &&
                     (!stage_q.valid || !fifo_full || pop);
  assign accept    = req_valid && req_ready;

  instr_word_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data ({next_addr, stage_q.word}),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stage_q    <= '0;
      next_addr  <= BASE_ADDR;
      word_count <= '0;
    end else begin
      if (accept)         stage_q       <= stage_t'({1'b1, enc});
      else if (stage_adv) stage_q.valid <= 1'b0;
      if (push) next_addr <= next_addr + ADDR_W'(4);
      if (pop && word_count != 16'hFFFF)
        word_count <= word_count + 16'd1;
    end
  end

  assign word_valid = !fifo_empty;
  assign word_data  = fifo_empty ? '0 : head_data[31:0];
  assign word_addr  = fifo_empty ? next_addr
                                 : head_data[EW-1:32];
  assign illegal_op = stage_q.valid && !stage_q.legal;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Scoreboard bench for instr_word_encoder: random and directed requests
// against a field-table reference model; monitor pops on each handshake.
module tb_instr_word_encoder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [4:0]  req_rs = '0;
  logic [4:0]  req_rt = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_shamt = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [31:0] word_data;
  logic [ADDR_W-1:0] word_addr;
  logic        illegal_op;
  logic [15:0] word_count;

  instr_word_encoder #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_rs(req_rs),
    .req_rt(req_rt),
    .req_rd(req_rd),
    .req_shamt(req_shamt),
    .req_imm(req_imm),
    .req_target(req_target),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data(word_data),
    .word_addr(word_addr),
    .illegal_op(illegal_op),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  int rfunct [7] = '{32, 34, 36, 37, 42, 0, 2};
  int iopc   [7] = '{8, 12, 13, 10, 35, 43, 4};

  logic [63:0] exp_q [$];
  logic [31:0] model_addr = BASE;
  int nchk = 0;
  int nerr = 0;
  int exp_ill = 0;
  int ill_seen = 0;
  int exp_words = 0;
  bit wr_force = 0;
  bit rand_rdy = 0;

  function automatic void ref_enc(
    input int op, input int rs, input int rt, input int rd,
    input int sh, input int imm, input int tgt,
    output bit ok, output logic [31:0] w);
    longint v;
    v = 0;
    ok = 1;
    if (op <= 6) begin
      v = (longint'(op >= 5 ? 0 : rs) << 21) + (longint'(rt) << 16)
        + (longint'(rd) << 11) + (longint'(sh) << 6) + rfunct[op];
`ifdef INSTR_WORD_ENCODER_FIELD_CHECK_EN
      if (op >= 5 && rs != 0) ok = 0;
      if (op < 5 && sh != 0) ok = 0;
      if (rd == 0) ok = 0;
`endif
    end else if (op <= 13) begin
      v = (longint'(iopc[op-7]) << 26) + (longint'(rs) << 21)
        + (longint'(rt) << 16) + imm;
`ifdef INSTR_WORD_ENCODER_FIELD_CHECK_EN
      if (op <= 11 && rt == 0) ok = 0;
`endif
    end else if (op == 14) begin
      v = (longint'(2) << 26) + tgt;
    end else begin
      ok = 0;
    end
    w = v[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_accept();
    bit ok;
    logic [31:0] w;
    ref_enc(int'(req_op), int'(req_rs), int'(req_rt), int'(req_rd),
            int'(req_shamt), int'(req_imm), int'(req_target), ok, w);
    if (ok) begin
      exp_q.push_back({model_addr, w});
      model_addr += 4;
      exp_words++;
    end else begin
      exp_ill++;
    end
  endtask

  task automatic set_req(input int op, input int rs, input int rt,
                         input int rd, input int sh, input int imm,
                         input int tgt);
    req_op = 4'(op);
    req_rs = 5'(rs);
    req_rt = 5'(rt);
    req_rd = 5'(rd);
    req_shamt = 5'(sh);
    req_imm = 16'(imm);
    req_target = 26'(tgt);
  endtask

  task automatic issue();
    int t;
    bit acc;
    t = 0;
    acc = 0;
    req_valid = 1;
    while (!acc && t < 100) begin
      @(negedge clock);
      acc = req_ready === 1'b1;
      if (acc) model_accept();
      @(posedge clock);
      #1;
      t++;
    end
    req_valid = 0;
    chk("accept_in_time", 64'(acc), 64'd1);
  endtask

  task automatic send(input int op, input int rs, input int rt,
                      input int rd, input int sh, input int imm,
                      input int tgt);
    set_req(op, rs, rt, rd, sh, imm, tgt);
    issue();
  endtask

  task automatic do_reset();
    wr_force = 0;
    rand_rdy = 0;
    req_valid = 0;
    reset_n = 0;
    @(posedge clock);
    #1;
    reset_n = 1;
    exp_q.delete();
    model_addr = BASE;
    exp_words = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    rand_rdy = 0;
    wr_force = 1;
    while ((exp_q.size() != 0 || word_valid === 1'b1) && t < 500) begin
      @(posedge clock);
      #1;
      t++;
    end
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    chk("drain_in_time", 64'(t < 500), 64'd1);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_word_count"}, 64'(word_count), 64'(exp_words));
    chk({tag, "_illegal_pulses"}, 64'(ill_seen), 64'(exp_ill));
    chk({tag, "_empty"}, 64'(word_valid), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      word_ready = rand_rdy ? 1'($urandom_range(0, 1)) : wr_force;
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1) begin
        if (illegal_op === 1'b1) ill_seen++;
        if (word_valid === 1'b1 && word_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_word: got %h @%h expected none",
                     word_data, word_addr);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", 64'(word_data), 64'(e[31:0]));
            chk("word_addr", 64'(word_addr), 64'(e[63:32]));
          end
        end
      end
    end
  end

  initial begin
    int n_acc;
    bit acc;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_word_valid", 64'(word_valid), 64'd0);
    chk("rst_word_data", 64'(word_data), 64'd0);
    chk("rst_word_addr", 64'(word_addr), 64'(BASE));
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1;
    @(negedge clock);
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1;

    send(0, 1, 2, 3, 0, 0, 0);
    @(negedge clock);
    chk("lat_stage_cycle", 64'(word_valid), 64'd0);
    @(negedge clock);
    chk("lat_word_cycle", 64'(word_valid), 64'd1);
    @(posedge clock);
    #1;
    drain();
    end_checks("add");

    do_reset();
    wr_force = 1;
    send(11, 0, 8, 0, 0, 4, 0);
    send(12, 0, 8, 0, 0, 8, 0);
    send(13, 1, 2, 0, 0, 16'hFFFF, 0);
    send(14, 0, 0, 0, 0, 0, 26'h10);
    drain();
    end_checks("stream");

    do_reset();
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_valid !== 1'b1) begin
        set_req(c % 5, 1 + c, 2, 3 + c, 0, 0, 0);
        req_valid = 1;
      end
      @(negedge clock);
      acc = req_ready === 1'b1;
      if (acc) begin
        model_accept();
        n_acc++;
      end
      @(posedge clock);
      #1;
      if (acc) req_valid = 0;
    end
    chk("stall_accepts", 64'(n_acc), 64'(DEPTH + 1));
    wr_force = 1;
    issue();
    drain();
    end_checks("stall");

    do_reset();
    wr_force = 1;
    send(9, 1, 2, 0, 0, 16'h1234, 0);
    send(15, 0, 0, 0, 0, 0, 0);
    send(9, 3, 4, 0, 0, 16'h00FF, 0);
    drain();
    end_checks("illegal");

    do_reset();
    send(7, 1, 5, 0, 0, 100, 0);
    send(7, 2, 6, 0, 0, 200, 0);
    send(7, 3, 7, 0, 0, 300, 0);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    do_reset();
    @(negedge clock);
    chk("midrst_word_valid", 64'(word_valid), 64'd0);
    chk("midrst_word_count", 64'(word_count), 64'd0);
    chk("midrst_word_addr", 64'(word_addr), 64'(BASE));
    @(posedge clock);
    #1;
    wr_force = 1;
    send(1, 4, 5, 6, 0, 0, 0);
    drain();
    end_checks("midrst");

    do_reset();
    wr_force = 1;
    send(5, 5, 2, 3, 4, 0, 0);
    send(6, 0, 2, 3, 1, 0, 0);
    drain();
    end_checks("shift");

    do_reset();
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      set_req($urandom_range(0, 15), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 65535),
              $urandom_range(0, 26'h3FFFFFF));
      issue();
    end
    drain();
    end_checks("random");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
